// File: rtl/ip_stack_array.sv
// ip_stack_array: MCS-4 style program-counter / subroutine-return stack.
// rows[sp] is the live PC; increment, load and readout each move one nibble per cycle.
module ip_stack_array #(
    parameter int NIBBLES = 3,
    parameter int DEPTH   = 4,
    localparam int AW     = 4 * NIBBLES,
    localparam int SW     = $clog2(DEPTH)
) (
    input  logic          sysclk,
    input  logic          poc_n,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    din,
    input  logic          din_valid,
    output logic [3:0]    dout,
    output logic          dout_valid,
    output logic [AW-1:0] pc,
    output logic [SW-1:0] level,
    output logic          ovf,
    output logic          unf,
    input  logic          clr_flags
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NIBBLES - 1);
    localparam logic [SW-1:0] LEVEL_MAX = SW'(DEPTH - 1);

    localparam logic [2:0] CMD_INC  = 3'd1;
    localparam logic [2:0] CMD_LOAD = 3'd2;
    localparam logic [2:0] CMD_CALL = 3'd3;
    localparam logic [2:0] CMD_RET  = 3'd4;
    localparam logic [2:0] CMD_READ = 3'd5;

    typedef enum logic [1:0] {ST_IDLE, ST_INC, ST_LOAD, ST_READ} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] rows_reg [DEPTH];
    logic [SW-1:0] sp_reg, sp_next;
    logic [SW-1:0] level_reg, level_next;
    logic [3:0]    tmp_reg [NIBBLES];
    logic [3:0]    tmp_next [NIBBLES];
    logic [IW-1:0] idx_reg, idx_next;
    logic          carry_reg, carry_next;
    logic          is_call_reg, is_call_next;
    logic          ready_reg;
    logic          ovf_reg, unf_reg;
    logic [3:0]    dout_reg, dout_next;
    logic          dv_reg, dv_next;

    logic          accept;
    logic          ovf_set, unf_set;
    logic          row_we;
    logic [SW-1:0] row_waddr;
    logic [AW-1:0] row_wdata;
    logic [4:0]    inc_sum;
    logic [3:0]    merge_nib;
    logic [3:0]    pc_nib [NIBBLES];

    assign accept     = cmd_valid & ready_reg;
    assign pc         = rows_reg[sp_reg];
    assign cmd_ready  = ready_reg;
    assign level      = level_reg;
    assign ovf        = ovf_reg;
    assign unf        = unf_reg;
    assign dout       = dout_reg;
    assign dout_valid = dv_reg;

    assign inc_sum   = {1'b0, tmp_reg[idx_reg]} + {4'b0000, carry_reg};
    assign merge_nib = (state_reg == ST_INC) ? inc_sum[3:0] : din;

    genvar gi;

    // The written row is tmp with the nibble finished this cycle merged in,
    // so the row is updated in one shot and pc never shows a partial value.
    for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign pc_nib[gi]            = pc[4*gi +: 4];
        assign row_wdata[4*gi +: 4]  = (idx_reg == IW'(gi)) ? merge_nib : tmp_reg[gi];
    end

    for (gi = 0; gi < DEPTH; gi++) begin : g_row
        logic [AW-1:0] row_q;
        always_ff @(posedge sysclk) begin
            if (!poc_n) begin
                row_q <= '0;
            end else if (row_we && (row_waddr == SW'(gi))) begin
                row_q <= row_wdata;
            end
        end
        assign rows_reg[gi] = row_q;
    end

    always_comb begin
        state_next   = state_reg;
        sp_next      = sp_reg;
        level_next   = level_reg;
        tmp_next     = tmp_reg;
        idx_next     = idx_reg;
        carry_next   = carry_reg;
        is_call_next = is_call_reg;
        dout_next    = 4'h0;
        dv_next      = 1'b0;
        ovf_set      = 1'b0;
        unf_set      = 1'b0;
        row_we       = 1'b0;
        row_waddr    = sp_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd)
                        CMD_INC: begin
                            tmp_next   = pc_nib;
                            carry_next = 1'b1;
                            idx_next   = '0;
                            state_next = ST_INC;
                        end
                        CMD_LOAD, CMD_CALL: begin
                            idx_next     = '0;
                            is_call_next = (cmd == CMD_CALL);
                            state_next   = ST_LOAD;
                        end
                        CMD_RET: begin
                            sp_next = sp_reg - 1'b1;
                            if (level_reg != '0) begin
                                level_next = level_reg - 1'b1;
                            end else begin
                                unf_set = 1'b1;
                            end
                        end
                        CMD_READ: begin
                            dout_next  = pc_nib[0];
                            dv_next    = 1'b1;
                            idx_next   = '0;
                            state_next = ST_READ;
                        end
                        default: ;
                    endcase
                end
            end

            ST_INC: begin
                tmp_next[idx_reg] = inc_sum[3:0];
                carry_next        = inc_sum[4];
                if (idx_reg == LAST_IDX) begin
                    row_we     = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end

            ST_LOAD: begin
                if (din_valid) begin
                    tmp_next[idx_reg] = din;
                    if (idx_reg == LAST_IDX) begin
                        row_we     = 1'b1;
                        state_next = ST_IDLE;
                        if (is_call_reg) begin
                            // A full stack wraps and overwrites the oldest return address.
                            row_waddr = sp_reg + 1'b1;
                            sp_next   = sp_reg + 1'b1;
                            if (level_reg != LEVEL_MAX) begin
                                level_next = level_reg + 1'b1;
                            end else begin
                                ovf_set = 1'b1;
                            end
                        end
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end

            ST_READ: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = ST_IDLE;
                end else begin
                    idx_next  = idx_reg + 1'b1;
                    dout_next = pc_nib[idx_reg + 1'b1];
                    dv_next   = 1'b1;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!poc_n) begin
            state_reg   <= ST_IDLE;
            sp_reg      <= '0;
            level_reg   <= '0;
            tmp_reg     <= '{default: 4'h0};
            idx_reg     <= '0;
            carry_reg   <= 1'b0;
            is_call_reg <= 1'b0;
            ready_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
            unf_reg     <= 1'b0;
            dout_reg    <= 4'h0;
            dv_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sp_reg      <= sp_next;
            level_reg   <= level_next;
            tmp_reg     <= tmp_next;
            idx_reg     <= idx_next;
            carry_reg   <= carry_next;
            is_call_reg <= is_call_next;
            ready_reg   <= (state_next == ST_IDLE);
            // A same-cycle set wins over clr_flags.
            ovf_reg     <= ovf_set | (ovf_reg & ~clr_flags);
            unf_reg     <= unf_set | (unf_reg & ~clr_flags);
            dout_reg    <= dout_next;
            dv_reg      <= dv_next;
        end
    end

endmodule

// File: tb/tb_ip_stack_array.sv
// Testbench for ip_stack_array: directed table, hand-written corner sequences,
// and random commands checked against an abstract PC/return-stack model.
module tb_ip_stack_array;
    localparam int NIBBLES = 3;
    localparam int DEPTH   = 4;
    localparam int AW      = 4 * NIBBLES;
    localparam int SW      = $clog2(DEPTH);

    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_INC  = 3'd1;
    localparam logic [2:0] C_LOAD = 3'd2;
    localparam logic [2:0] C_CALL = 3'd3;
    localparam logic [2:0] C_RET  = 3'd4;
    localparam logic [2:0] C_READ = 3'd5;

    logic          sysclk    = 1'b0;
    logic          poc_n     = 1'b0;
    logic [2:0]    cmd       = 3'd0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    din       = 4'h0;
    logic          din_valid = 1'b0;
    logic [3:0]    dout;
    logic          dout_valid;
    logic [AW-1:0] pc;
    logic [SW-1:0] level;
    logic          ovf;
    logic          unf;
    logic          clr_flags = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    // Abstract model: array of return addresses plus a wrapping pointer.
    int m_rows [DEPTH];
    int m_sp;
    int m_level;
    int m_ovf;
    int m_unf;

    typedef struct {
        logic [2:0] c;
        int         v;
        int         exp_pc;
        int         exp_level;
        int         exp_ovf;
        int         exp_unf;
    } vec_t;

    vec_t tbl [13];

    ip_stack_array #(.NIBBLES(NIBBLES), .DEPTH(DEPTH)) dut (
        .sysclk     (sysclk),
        .poc_n      (poc_n),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .pc         (pc),
        .level      (level),
        .ovf        (ovf),
        .unf        (unf),
        .clr_flags  (clr_flags)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end else begin
            $display("ok   %s: 0x%0h", name, actual);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++) m_rows[r] = 0;
        m_sp = 0; m_level = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_op(input logic [2:0] c, input int v, input bit clr);
        if (clr) begin
            m_ovf = 0;
            m_unf = 0;
        end
        case (c)
            C_INC:  m_rows[m_sp] = (m_rows[m_sp] + 1) % (1 << AW);
            C_LOAD: m_rows[m_sp] = v;
            C_CALL: begin
                m_sp = (m_sp + 1) % DEPTH;
                m_rows[m_sp] = v;
                if (m_level < DEPTH - 1) m_level++;
                else m_ovf = 1;
            end
            C_RET: begin
                m_sp = (m_sp + DEPTH - 1) % DEPTH;
                if (m_level > 0) m_level--;
                else m_unf = 1;
            end
            default: ;
        endcase
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("ready_timeout", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic send_cmd(input logic [2:0] c, input bit clr);
        wait_ready();
        cmd       = c;
        cmd_valid = 1'b1;
        clr_flags = clr;
        tick();
        cmd_valid = 1'b0;
        clr_flags = 1'b0;
        cmd       = C_NOP;
    endtask

    task automatic send_data(input int value, input int gap_max);
        logic [AW-1:0] v;
        v = AW'(value);
        for (int n = 0; n < NIBBLES; n++) begin
            repeat ($urandom_range(0, gap_max)) begin
                din       = 4'($urandom);
                din_valid = 1'b0;
                tick();
            end
            din       = v[4*n +: 4];
            din_valid = 1'b1;
            tick();
            din_valid = 1'b0;
        end
    endtask

    // Runs one command to completion and updates the model; READ checks the readout.
    task automatic exec_op(input logic [2:0] c, input int value, input bit clr, input int gap_max);
        logic [AW-1:0] exp_row;
        send_cmd(c, clr);
        if (c == C_LOAD || c == C_CALL) begin
            send_data(value, gap_max);
        end else if (c == C_READ) begin
            exp_row = AW'(m_rows[m_sp]);
            for (int n = 0; n < NIBBLES; n++) begin
                check($sformatf("read_valid[%0d]", n), {31'd0, dout_valid}, 32'd1);
                check($sformatf("read_nib[%0d]", n), {28'd0, dout}, {28'd0, exp_row[4*n +: 4]});
                tick();
            end
            check("read_end_valid", {31'd0, dout_valid}, 32'd0);
            check("read_end_dout", {28'd0, dout}, 32'd0);
        end
        wait_ready();
        model_op(c, value, clr);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_pc"},    pc,    m_rows[m_sp]);
        check({tag, "_level"}, level, m_level);
        check({tag, "_ovf"},   ovf,   m_ovf);
        check({tag, "_unf"},   unf,   m_unf);
    endtask

    initial begin
        logic [2:0] c;
        int         v;
        int         waits;
        bit         accepted;
        bit         rdy;
        bit         clr;
        int         pat [5];
        int         nibs [3];
        int         j;
        logic [AW-1:0] rd;

        tbl[0]  = '{C_LOAD, 'h0FF, 'h0FF, 0, 0, 0};
        tbl[1]  = '{C_INC,  0,     'h100, 0, 0, 0};
        tbl[2]  = '{C_LOAD, 'h123, 'h123, 0, 0, 0};
        tbl[3]  = '{C_INC,  0,     'h124, 0, 0, 0};
        tbl[4]  = '{C_LOAD, 'h123, 'h123, 0, 0, 0};
        tbl[5]  = '{C_CALL, 'h456, 'h456, 1, 0, 0};
        tbl[6]  = '{C_CALL, 'h789, 'h789, 2, 0, 0};
        tbl[7]  = '{C_CALL, 'hABC, 'hABC, 3, 0, 0};
        tbl[8]  = '{C_CALL, 'hDEF, 'hDEF, 3, 1, 0};
        tbl[9]  = '{C_RET,  0,     'hABC, 2, 1, 0};
        tbl[10] = '{C_RET,  0,     'h789, 1, 1, 0};
        tbl[11] = '{C_RET,  0,     'h456, 0, 1, 0};
        tbl[12] = '{C_RET,  0,     'hDEF, 0, 1, 1};

        // Reset state
        model_reset();
        poc_n = 1'b0;
        tick();
        tick();
        check("rst_ready_low", {31'd0, cmd_ready}, 32'd0);
        check("rst_pc", pc, 32'h000);
        check("rst_level", level, 32'd0);
        check("rst_ovf", ovf, 32'd0);
        check("rst_unf", unf, 32'd0);
        check("rst_dout_valid", dout_valid, 32'd0);
        poc_n = 1'b1;
        tick();
        check("rst_release_ready", {31'd0, cmd_ready}, 32'd1);

        // LOAD 0x5A3 with din_valid gaps: pc holds 0 until the 5th edge
        pat  = '{1, 0, 0, 1, 1};
        nibs = '{3, 'hA, 5};
        j = 0;
        send_cmd(C_LOAD, 1'b0);
        for (int k = 0; k < 5; k++) begin
            din_valid = pat[k][0];
            if (pat[k] != 0) begin
                din = 4'(nibs[j]);
                j++;
            end else begin
                din = 4'hF;
            end
            tick();
            check($sformatf("load_gap_pc[%0d]", k), pc, (k < 4) ? 32'h000 : 32'h5A3);
        end
        din_valid = 1'b0;
        model_op(C_LOAD, 'h5A3, 1'b0);
        exec_op(C_READ, 0, 1'b0, 0);

        // INC held during READ: accepted only once the read finishes, exactly once
        wait_ready();
        rd = pc;
        cmd = C_READ;
        cmd_valid = 1'b1;
        tick();
        cmd = C_INC;
        waits = 0;
        accepted = 1'b0;
        for (int k = 0; k < 20 && !accepted; k++) begin
            rdy = cmd_ready;
            if (k < NIBBLES) check($sformatf("busy_read_nib[%0d]", k), {28'd0, dout}, {28'd0, rd[4*k +: 4]});
            tick();
            waits++;
            if (rdy) accepted = 1'b1;
        end
        cmd_valid = 1'b0;
        cmd = C_NOP;
        check("busy_accept_wait", waits, NIBBLES + 1);
        wait_ready();
        repeat (3) tick();
        model_op(C_INC, 0, 1'b0);
        check("busy_single_inc_pc", pc, 32'h5A4);

        // LOAD FFF then INC: busy for NIBBLES cycles, then wraps to 000
        exec_op(C_LOAD, 'hFFF, 1'b0, 1);
        send_cmd(C_INC, 1'b0);
        for (int k = 0; k < NIBBLES; k++) begin
            check($sformatf("inc_busy_ready[%0d]", k), {31'd0, cmd_ready}, 32'd0);
            check($sformatf("inc_busy_pc[%0d]", k), pc, 32'hFFF);
            tick();
        end
        check("inc_done_ready", {31'd0, cmd_ready}, 32'd1);
        check("inc_wrap_pc", pc, 32'h000);
        model_op(C_INC, 0, 1'b0);

        // Directed increment/stack table
        for (int t = 0; t < 13; t++) begin
            exec_op(tbl[t].c, tbl[t].v, 1'b0, 1);
            check($sformatf("tbl[%0d]_pc", t),    pc,    tbl[t].exp_pc);
            check($sformatf("tbl[%0d]_level", t), level, tbl[t].exp_level);
            check($sformatf("tbl[%0d]_ovf", t),   ovf,   tbl[t].exp_ovf);
            check($sformatf("tbl[%0d]_unf", t),   unf,   tbl[t].exp_unf);
        end

        // RET keeps cmd_ready high; clr_flags clears; set beats same-cycle clear
        check("ret_ready_high", {31'd0, cmd_ready}, 32'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        model_op(C_NOP, 0, 1'b1);
        check("clr_ovf", ovf, 32'd0);
        check("clr_unf", unf, 32'd0);
        exec_op(C_RET, 0, 1'b1, 0);
        check_model("ret_clr_same_cycle");
        check("set_beats_clr_unf", unf, 32'd1);

        // Reset during the 2nd INC cycle from 0x0FF: no 0x100 writeback
        exec_op(C_LOAD, 'h0FF, 1'b0, 0);
        send_cmd(C_INC, 1'b0);
        tick();
        poc_n = 1'b0;
        tick();
        check("midrst_pc", pc, 32'h000);
        check("midrst_ready", {31'd0, cmd_ready}, 32'd0);
        poc_n = 1'b1;
        tick();
        check("midrst_release_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (NIBBLES) tick();
        model_reset();
        check_model("midrst_settled");

        // Randomized commands against the model
        for (int r = 0; r < 150; r++) begin
            c = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: v = 'hFFF;
                1: v = 'h0FF;
                default: v = int'($urandom_range(0, (1 << AW) - 1));
            endcase
            clr = ($urandom_range(0, 9) == 0);
            exec_op(c, v, clr, 2);
            check_model($sformatf("rnd[%0d]", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
